alu_seq: RTL

Parametrised, handshaked successor to the 32-bit combinational ALU. Keeps the eight-op command set (ADD, SUB, XOR, SLT, AND, NAND, NOR, OR) and its carryout/zero/overflow flags, at any WIDTH. Adds an iterative shift-add unsigned multiplier (low and high halves) and registered valid/ready ports on both sides, so it can sit in a pipelined datapath stage.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_core.sv | 49 ++++
 rtl/alu_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared command codes and FSM state encoding
// for the handshaked sequential ALU (alu_core, alu_seq).
package alu_seq_pkg;

    localparam logic [3:0] CMD_ADD  = 4'd0;
    localparam logic [3:0] CMD_SUB  = 4'd1;
    localparam logic [3:0] CMD_XOR  = 4'd2;
    localparam logic [3:0] CMD_SLT  = 4'd3;
    localparam logic [3:0] CMD_AND  = 4'd4;
    localparam logic [3:0] CMD_NAND = 4'd5;
    localparam logic [3:0] CMD_NOR  = 4'd6;
    localparam logic [3:0] CMD_OR   = 4'd7;
    localparam logic [3:0] CMD_MUL  = 4'd8;
    localparam logic [3:0] CMD_MULH = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        MULT = 1'b1
    } state_e;

    function automatic logic is_mul(input logic [3:0] cmd);
        return (cmd == CMD_MUL) || (cmd == CMD_MULH);
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational WIDTH-bit datapath for commands 0-7.
// Ports: cmd_i, a_i, b_i in; result_o, carry_o, overflow_o out.
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       cmd_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             overflow_o
);

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             ovf;

    // SLT shares the subtractor; its sign is corrected by overflow.
    assign sub   = (cmd_i == CMD_SUB) || (cmd_i == CMD_SLT);
    assign b_eff = sub ? ~b_i : b_i;
    assign sum   = {1'b0, a_i} + {1'b0, b_eff}
                 + {{WIDTH{1'b0}}, sub};
    assign ovf   = (a_i[WIDTH-1] == b_eff[WIDTH-1])
                && (sum[WIDTH-1] != a_i[WIDTH-1]);

    always_comb begin
        result_o   = '0;
        carry_o    = 1'b0;
        overflow_o = 1'b0;
        unique case (cmd_i)
            CMD_ADD, CMD_SUB: begin
                result_o   = sum[WIDTH-1:0];
                carry_o    = sum[WIDTH];
                overflow_o = ovf;
            end
            CMD_XOR:  result_o = a_i ^ b_i;
            CMD_SLT:  result_o[0] = sum[WIDTH-1] ^ ovf;
            CMD_AND:  result_o = a_i & b_i;
            CMD_NAND: result_o = ~(a_i & b_i);
            CMD_NOR:  result_o = ~(a_i | b_i);
            CMD_OR:   result_o = a_i | b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU with shift-add MUL/MULH and output register.
// Ports: clk, rst_n, in_* command side, out_* result side, flags.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       command,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               mulh_q, mulh_d;

    logic [WIDTH-1:0]   core_res;
    logic               core_c;
    logic               core_o;
    logic [2*WIDTH-1:0] acc_step;
    logic               accept;
    logic               load;
    logic [WIDTH-1:0]   load_res;
    logic               load_c;
    logic               load_o;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .cmd_i      (command),
        .a_i        (operandA),
        .b_i        (operandB),
        .result_o   (core_res),
        .carry_o    (core_c),
        .overflow_o (core_o)
    );

    // Entry only when the output register is empty or draining,
    // so a finishing multiply always has a free slot.
    assign in_ready = (state_q == IDLE)
                   && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mulh_d      = mulh_q;
        load        = 1'b0;
        load_res    = '0;
        load_c      = 1'b0;
        load_o      = 1'b0;

        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mul(command)) begin
                        mcand_d  = {{WIDTH{1'b0}}, operandA};
                        mplier_d = operandB;
                        acc_d    = '0;
                        cnt_d    = CNT_INIT;
                        mulh_d   = (command == CMD_MULH);
                        state_d  = MULT;
                    end else begin
                        load     = 1'b1;
                        load_res = core_res;
                        load_c   = core_c;
                        load_o   = core_o;
                    end
                end
            end
            MULT: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d  = IDLE;
                    load     = 1'b1;
                    load_res = mulh_q ? acc_step[2*WIDTH-1:WIDTH]
                                      : acc_step[WIDTH-1:0];
                    load_o   = !mulh_q
                            && (acc_step[2*WIDTH-1:WIDTH] != '0);
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            result_d    = load_res;
            carry_d     = load_c;
            ovf_d       = load_o;
            zero_d      = (load_res == '0);
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            mulh_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mulh_q      <= mulh_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carryout  = carry_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;

endmodule
